// File: rtl/mul_div_unit.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiply and restoring
// divide on operand magnitudes, fixed XLEN+1 cycle latency for every op.
module mul_div_unit #(
  parameter int unsigned XLEN = 32
) (
  input  logic            CLK,
  input  logic            RST_N,
  input  logic            START,
  input  logic [2:0]      FUN3,
  input  logic [XLEN-1:0] RS1,
  input  logic [XLEN-1:0] RS2,
  input  logic            FLUSH,
  output logic            BUSY,
  output logic            DONE,
  output logic [XLEN-1:0] RESULT
);

  localparam int unsigned CNT_W = $clog2(XLEN);
  localparam int unsigned PW    = 2 * XLEN;

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_BUSY = 2'b01;
  localparam logic [1:0] ST_DONE = 2'b10;

  localparam logic [2:0] F_MUL    = 3'b000;
  localparam logic [2:0] F_MULH   = 3'b001;
  localparam logic [2:0] F_MULHSU = 3'b010;
  localparam logic [2:0] F_MULHU  = 3'b011;
  localparam logic [2:0] F_DIV    = 3'b100;
  localparam logic [2:0] F_DIVU   = 3'b101;
  localparam logic [2:0] F_REM    = 3'b110;

  localparam logic [XLEN-1:0] INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0] ALL_ONES = {XLEN{1'b1}};

  logic [1:0]       state, state_nx;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       fun3_q;
  logic [XLEN-1:0]  rs1_q;
  logic             sign_a_q, sign_b_q, dz_q, ovf_q;
  logic [XLEN-1:0]  a_q, a_nx;   // multiplier, or dividend shifting into quotient
  logic [PW-1:0]    b_q, b_nx;   // multiplicand, or divisor in the low half
  logic [PW-1:0]    p_q, p_nx;   // product, or partial remainder in the low half

  logic             sign_a_c, sign_b_c, accept_c, last_c;
  logic [XLEN-1:0]  mag_a_c, mag_b_c;
  logic [XLEN:0]    rem_sh_c, diff_c;
  logic [PW-1:0]    prod_c;
  logic [XLEN-1:0]  quo_c, rem_c, res_c;

  // State bits are one-hot, so the status outputs are straight flop outputs
  assign BUSY = state[0];
  assign DONE = state[1];

  assign sign_a_c = RS1[XLEN-1] & ((FUN3 == F_MULH) | (FUN3 == F_MULHSU) |
                                   (FUN3 == F_DIV)  | (FUN3 == F_REM));
  assign sign_b_c = RS2[XLEN-1] & ((FUN3 == F_MULH) | (FUN3 == F_DIV) | (FUN3 == F_REM));
  assign mag_a_c  = sign_a_c ? (~RS1 + XLEN'(1)) : RS1;
  assign mag_b_c  = sign_b_c ? (~RS2 + XLEN'(1)) : RS2;
  assign accept_c = (state == ST_IDLE) & START & ~FLUSH;
  assign last_c   = (cnt == CNT_W'(XLEN - 1));

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state <= ST_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: if (START) state_nx = ST_BUSY;
      ST_BUSY: if (last_c) state_nx = ST_DONE;
      ST_DONE: state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
    if (FLUSH) state_nx = ST_IDLE;
  end

  // One radix-2 step of whichever operation is in flight
  always_comb begin
    a_nx     = a_q;
    b_nx     = b_q;
    p_nx     = p_q;
    rem_sh_c = {p_q[XLEN-1:0], a_q[XLEN-1]};
    diff_c   = rem_sh_c - {1'b0, b_q[XLEN-1:0]};
    if (fun3_q[2]) begin
      if (!diff_c[XLEN]) begin
        p_nx = {XLEN'(0), diff_c[XLEN-1:0]};
        a_nx = {a_q[XLEN-2:0], 1'b1};
      end else begin
        p_nx = {XLEN'(0), rem_sh_c[XLEN-1:0]};
        a_nx = {a_q[XLEN-2:0], 1'b0};
      end
    end else begin
      if (a_q[0]) p_nx = p_q + b_q;
      b_nx = {b_q[PW-2:0], 1'b0};
      a_nx = {1'b0, a_q[XLEN-1:1]};
    end
  end

  // Final result from the post-step values, with special cases overriding
  always_comb begin
    prod_c = (sign_a_q ^ sign_b_q) ? (~p_nx + PW'(1)) : p_nx;
    quo_c  = (sign_a_q ^ sign_b_q) ? (~a_nx + XLEN'(1)) : a_nx;
    rem_c  = sign_a_q ? (~p_nx[XLEN-1:0] + XLEN'(1)) : p_nx[XLEN-1:0];
    res_c  = '0;
    case (fun3_q)
      F_MUL:                     res_c = prod_c[XLEN-1:0];
      F_MULH, F_MULHSU, F_MULHU: res_c = prod_c[PW-1:XLEN];
      F_DIV, F_DIVU:             res_c = dz_q ? ALL_ONES : (ovf_q ? INT_MIN : quo_c);
      default:                   res_c = dz_q ? rs1_q : (ovf_q ? XLEN'(0) : rem_c);
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      cnt      <= '0;
      fun3_q   <= '0;
      rs1_q    <= '0;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      dz_q     <= 1'b0;
      ovf_q    <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      p_q      <= '0;
      RESULT   <= '0;
    end else if (accept_c) begin
      cnt      <= '0;
      fun3_q   <= FUN3;
      rs1_q    <= RS1;
      sign_a_q <= sign_a_c;
      sign_b_q <= sign_b_c;
      dz_q     <= FUN3[2] & (RS2 == '0);
      ovf_q    <= ((FUN3 == F_DIV) | (FUN3 == F_REM)) & (RS1 == INT_MIN) & (RS2 == ALL_ONES);
      p_q      <= '0;
      if (FUN3[2]) begin
        a_q <= mag_a_c;
        b_q <= {XLEN'(0), mag_b_c};
      end else begin
        a_q <= mag_b_c;
        b_q <= {XLEN'(0), mag_a_c};
      end
    end else if ((state == ST_BUSY) && !FLUSH) begin
      cnt <= cnt + CNT_W'(1);
      a_q <= a_nx;
      b_q <= b_nx;
      p_q <= p_nx;
      if (last_c) RESULT <= res_c;
    end
  end

endmodule
